// File: rtl/fxp8s_pe_seq.sv
// fxp8s_pe_seq: command sequencer / result collector around one fxp8s_pe.
// Ports: clk, rstn (async low); cmd_* command in (len, weight);
//   act_* activation stream; pe_* PE load/mul/done/readout protocol;
//   res_* per-command delta of the PE accumulator out (valid/ready).
module fxp8s_pe_seq #(
   parameter int LEN_W = 4,
   parameter int DRAIN = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [7:0]       cmd_weight,
   input  logic             act_valid,
   output logic             act_ready,
   input  logic [7:0]       act_data,
   output logic             pe_en_in,
   output logic             pe_in_buf,
   output logic [7:0]       pe_in_data,
   output logic             pe_in_done,
   input  logic             pe_en_out,
   output logic             pe_rdy_out,
   input  logic [7:0]       pe_out_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_data
);

   localparam int DW = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STREAM,
      S_DRAIN,
      S_COLLECT,
      S_RESP
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [LEN_W-1:0] len_r;
   logic [7:0]       wt_r;
   logic [LEN_W-1:0] cnt;
   logic [DW-1:0]    dcnt;
   logic [7:0]       base;
   logic [7:0]       res_r;
   logic             last;

   assign last = (cnt == len_r - LEN_W'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      cmd_ready  = 1'b0;
      act_ready  = 1'b0;
      pe_en_in   = 1'b0;
      pe_in_buf  = 1'b0;
      pe_in_data = 8'h00;
      pe_in_done = 1'b0;
      pe_rdy_out = 1'b0;
      res_valid  = 1'b0;
      res_data   = 8'h00;
      unique case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid)
               state_n = (cmd_len == '0) ? S_RESP : S_LOAD;
         end
         S_LOAD: begin
            pe_en_in   = 1'b1;
            pe_in_buf  = 1'b1;
            pe_in_data = wt_r;
            state_n    = S_STREAM;
         end
         S_STREAM: begin
            act_ready  = 1'b1;
            pe_en_in   = act_valid;
            pe_in_data = act_data;
            pe_in_done = act_valid & last;
            if (act_valid && last) state_n = S_DRAIN;
         end
         S_DRAIN: begin
            if (dcnt == DW'(1)) state_n = S_COLLECT;
         end
         S_COLLECT: begin
            pe_rdy_out = pe_en_out;
            if (pe_en_out) state_n = S_RESP;
         end
         S_RESP: begin
            res_valid = 1'b1;
            res_data  = res_r;
            if (res_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // The PE accumulator is never cleared, so each result is the delta
   // against the previous readout held in base.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         len_r <= '0;
         wt_r  <= 8'h00;
         cnt   <= '0;
         dcnt  <= '0;
         base  <= 8'h00;
         res_r <= 8'h00;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  len_r <= cmd_len;
                  wt_r  <= cmd_weight;
                  if (cmd_len == '0) res_r <= 8'h00;
               end
            end
            S_LOAD: cnt <= '0;
            S_STREAM: begin
               if (act_valid) begin
                  cnt <= cnt + LEN_W'(1);
                  if (last) dcnt <= DW'(DRAIN);
               end
            end
            S_DRAIN: dcnt <= dcnt - DW'(1);
            S_COLLECT: begin
               if (pe_en_out) begin
                  res_r <= pe_out_data - base;
                  base  <= pe_out_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fxp8s_pe_seq.sv
// tb_fxp8s_pe_seq: scoreboard bench for fxp8s_pe_seq with a PE stub.
// Stub raises en_out one cycle after in_done and returns stub_val.
module tb_fxp8s_pe_seq;

   localparam int LEN_W = 4;
   localparam int DRAIN = 2;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic [7:0]       cmd_weight;
   logic             act_valid;
   logic             act_ready;
   logic [7:0]       act_data;
   logic             pe_en_in;
   logic             pe_in_buf;
   logic [7:0]       pe_in_data;
   logic             pe_in_done;
   logic             pe_en_out;
   logic             pe_rdy_out;
   logic [7:0]       pe_out_data;
   logic             res_valid;
   logic             res_ready;
   logic [7:0]       res_data;

   fxp8s_pe_seq #(.LEN_W(LEN_W), .DRAIN(DRAIN)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_len(cmd_len), .cmd_weight(cmd_weight),
      .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
      .pe_en_in(pe_en_in), .pe_in_buf(pe_in_buf),
      .pe_in_data(pe_in_data), .pe_in_done(pe_in_done),
      .pe_en_out(pe_en_out), .pe_rdy_out(pe_rdy_out),
      .pe_out_data(pe_out_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [7:0] stub_val;
   assign pe_out_data = stub_val;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) pe_en_out <= 1'b0;
      else if (pe_in_done) pe_en_out <= 1'b1;
      else if (pe_rdy_out && pe_en_out) pe_en_out <= 1'b0;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] sb[$];
   logic [7:0] base_m = 8'h00;
   logic [7:0] acts[$];

   int   c0 = 0;
   bit   en_a[32];
   bit   buf_a[32];
   bit   done_a[32];
   bit   rdy_a[32];
   bit   rv_a[32];
   logic [7:0] dat_a[32];
   int   en_n = 0;
   int   act_n = 0;
   int   done_n = 0;
   int   rdy_n = 0;

   always @(negedge clk) begin
      int rel;
      if (cmd_valid && cmd_ready) begin
         c0 = cyc;
         for (int i = 0; i < 32; i++) begin
            en_a[i] = 0; buf_a[i] = 0; done_a[i] = 0;
            rdy_a[i] = 0; rv_a[i] = 0; dat_a[i] = 8'h00;
         end
         en_n = 0; act_n = 0; done_n = 0; rdy_n = 0;
      end
      rel = cyc - c0;
      if (rel >= 0 && rel < 32) begin
         en_a[rel]   = pe_en_in;
         buf_a[rel]  = pe_in_buf;
         done_a[rel] = pe_in_done;
         rdy_a[rel]  = pe_rdy_out;
         rv_a[rel]   = res_valid;
         dat_a[rel]  = pe_in_data;
      end
      if (pe_en_in) en_n++;
      if (pe_en_in && !pe_in_buf) act_n++;
      if (pe_in_done) done_n++;
      if (pe_rdy_out) rdy_n++;
      if (res_valid && res_ready) begin
         if (sb.size() == 0) check("sb_empty", 1, 0);
         else check("res", res_data, sb.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input int len, input logic [7:0] wt,
                         input logic [7:0] stub, input bit bubble,
                         input int hold);
      int n;
      stub_val = stub;
      if (len == 0) sb.push_back(8'h00);
      else begin
         sb.push_back(8'(stub - base_m));
         base_m = stub;
      end
      cmd_len    = len[LEN_W-1:0];
      cmd_weight = wt;
      cmd_valid  = 1'b1;
      res_ready  = (hold == 0);
      n = 0;
      while (!cmd_ready && n < 50) begin tick(); n++; end
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < len; i++) begin
         n = 0;
         while (!act_ready && n < 50) begin tick(); n++; end
         if (n >= 50) check("act_tmo", 0, 1);
         act_valid = 1'b1;
         act_data  = acts[i];
         tick();
         act_valid = 1'b0;
         if (bubble && i < len - 1) tick();
      end
      if (hold > 0) begin
         n = 0;
         while (!res_valid && n < 50) begin tick(); n++; end
         for (int k = 0; k < hold; k++) begin
            check("hold_v", res_valid, 1);
            check("hold_d", res_data, sb.size() > 0 ? sb[0] : 8'hxx);
            check("hold_cr", cmd_ready, 0);
            tick();
         end
         res_ready = 1'b1;
      end
      n = 0;
      while (sb.size() != 0 && n < 100) begin tick(); n++; end
      if (sb.size() != 0) begin
         check("res_tmo", 0, 1);
         sb.delete();
      end
   endtask

   initial begin
      cmd_valid = 0; cmd_len = '0; cmd_weight = 0;
      act_valid = 0; act_data = 0; res_ready = 1; stub_val = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cr", cmd_ready, 1);
      check("rst_rv", res_valid, 0);
      check("rst_rd", res_data, 0);
      check("rst_ar", act_ready, 0);
      check("rst_pe", {pe_en_in, pe_in_buf, pe_in_data,
                       pe_in_done, pe_rdy_out}, 0);
      rstn = 1'b1;
      tick();

      acts = '{8'h10, 8'h18, 8'h08};
      do_cmd(3, 8'h08, 8'h30, 0, 0);
      check("ld_en", {en_a[1], buf_a[1]}, 2'b11);
      check("ld_dat", dat_a[1], 8'h08);
      check("a0", {en_a[2], buf_a[2], dat_a[2]}, {2'b10, 8'h10});
      check("a1", {en_a[3], buf_a[3], dat_a[3]}, {2'b10, 8'h18});
      check("a2", {en_a[4], buf_a[4], dat_a[4]}, {2'b10, 8'h08});
      check("done_c4", done_a[4], 1);
      check("done_n", done_n, 1);
      check("en_n", en_n, 4);
      check("rdy_c7", rdy_a[7], 1);
      check("rdy_n", rdy_n, 1);
      check("rv_c7", rv_a[7], 0);
      check("rv_c8", rv_a[8], 1);

      acts = '{8'h01, 8'h02};
      do_cmd(2, 8'h03, 8'h50, 0, 0);
      do_cmd(2, 8'h03, 8'h40, 0, 0);
      do_cmd(2, 8'h03, 8'hF0, 0, 0);
      do_cmd(2, 8'h03, 8'h10, 0, 0);

      do_cmd(0, 8'h05, 8'hAA, 0, 0);
      check("z_en", en_n, 0);
      check("z_rv0", rv_a[0], 0);
      check("z_rv1", rv_a[1], 1);

      acts = '{8'h01, 8'h02, 8'h03, 8'h04};
      do_cmd(4, 8'h02, 8'h77, 1, 5);
      check("bb_act", act_n, 4);
      check("bb_done", done_n, 1);
      check("bb_rdy", rdy_n, 1);

      cmd_valid = 1; cmd_len = 3; cmd_weight = 8'h02;
      tick();
      cmd_valid = 0;
      tick();
      act_valid = 1; act_data = 8'h11;
      tick();
      act_data = 8'h22;
      tick();
      act_data = 8'h33;
      #2;
      rstn = 1'b0;
      #1;
      check("mr_cr", cmd_ready, 1);
      check("mr_ar", act_ready, 0);
      check("mr_pe", {pe_en_in, pe_in_done, pe_rdy_out}, 0);
      check("mr_rv", {res_valid, res_data}, 0);
      act_valid = 0;
      base_m = 8'h00;
      tick();
      rstn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check("mr_norv", res_valid, 0);
         tick();
      end
      acts = '{8'h01};
      do_cmd(1, 8'h08, 8'h08, 0, 0);

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
